rr_arb_idx: RTL and testbench
=============================

RR_ARB_IDX -- requirements
Module: rr_arb_idx

Interface
REQ-001 Parameter BITS, default 2, width of the binary grant index.
REQ-002 Parameter SIZE, default 4, number of requesters; legal range 2 <= SIZE <= 2**BITS.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 req  input  SIZE  per-requester request level, bit i = requester i.
REQ-006 idx_valid  output  1  registered; a grant index is being offered downstream.
REQ-007 idx_ready  input  1  downstream one-hot decoder stage accepts idx this cycle.
REQ-008 idx  output  BITS  registered binary index of the granted requester.
REQ-009 ptr  output  BITS  registered round-robin pointer, for debug and observation.

Function
REQ-010 The block SHALL implement a two-state FSM: ST_IDLE (idx_valid=0) and ST_GRANT (idx_valid=1).
REQ-011 In ST_IDLE with req!=0 at a clock edge, the block SHALL load idx with the first set req bit found scanning upward from ptr with wrap at SIZE-1 to 0, and SHALL enter ST_GRANT; latency is 1 cycle.
REQ-012 In ST_IDLE with req==0, the block SHALL stay in ST_IDLE with idx and ptr unchanged.
REQ-013 In ST_GRANT with idx_ready=0, idx and idx_valid SHALL hold stable, even if req[idx] deasserts (no grant retraction).
REQ-014 A handshake (idx_valid & idx_ready) SHALL set ptr to idx+1, wrapping to 0 when idx==SIZE-1.
REQ-015 On a handshake cycle with req!=0, the block SHALL stay in ST_GRANT and load a new idx by scanning from the updated ptr value, giving 1 grant per cycle throughput.
REQ-016 On a handshake cycle with req==0, the block SHALL return to ST_IDLE.
REQ-017 req bits at positions >= SIZE do not exist; idx SHALL never exceed SIZE-1.
REQ-018 idx_ready while in ST_IDLE SHALL be ignored.

Reset
REQ-019 When rst=1 at a clock edge, the block SHALL set state=ST_IDLE, idx_valid=0, idx=0 and ptr=0, overriding any handshake or request in that cycle.
REQ-020 A reset asserted mid-grant SHALL drop the pending grant without advancing ptr.

Configuration
REQ-021 Macro RR_ARB_LOCK_EN SHALL add an input port lock (1 bit).
REQ-022 With RR_ARB_LOCK_EN defined, a handshake with lock=1 and req[idx]=1 SHALL re-grant the same idx next cycle, with ptr left unchanged.
REQ-023 With RR_ARB_LOCK_EN defined, a handshake with lock=1 and req[idx]=0 SHALL behave as REQ-014 to REQ-016.
REQ-024 Without RR_ARB_LOCK_EN, the lock port SHALL be absent and behaviour SHALL be exactly REQ-010 to REQ-018.

Structure
REQ-025 The shared package/include SHALL hold the state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1, and the SIZE <= 2**BITS legality check.
REQ-026 The combinational wrap-around scan SHALL be one sub-module rr_pick (inputs req and start; outputs found and index), instantiated once.
REQ-027 idx SHALL feed the downstream binary-to-one-hot decoder directly, with no extra pipeline stage.

Verification
REQ-028 Reset then req=4'b1111 with idx_ready=1 held -> idx sequence 0,1,2,3,0 on consecutive cycles, idx_valid=1 continuously.
REQ-029 req=4'b0100 pulsed for 1 cycle with idx_ready=0 -> idx=2, idx_valid held high for 5 cycles; then idx_ready=1 -> ptr=3, return to ST_IDLE.
REQ-030 ptr=3 and req=4'b1001 -> idx=3; after handshake, next idx=0 (wrap).
REQ-031 rst=1 asserted during ST_GRANT with idx=1 and idx_ready=1 -> next cycle idx_valid=0, idx=0, ptr=0.
REQ-032 With RR_ARB_LOCK_EN defined, req=4'b0011 and lock=1 for 3 handshakes -> idx=0,0,0; lock=0 -> idx=1.
REQ-033 SIZE=3, BITS=2 with req=3'b111 -> idx cycles 0,1,2,0 and never reaches 3.

Source files
------------

// File: rtl/rr_arb_idx_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_idx_pkg
// Shared definitions for the round-robin index arbiter:
//   - st_e       : FSM state encoding (ST_IDLE / ST_GRANT)
//   - size_legal : parameter legality check, 2 <= SIZE <= 2**BITS
// ---------------------------------------------------------------------------
package rr_arb_idx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } st_e;

    function automatic bit size_legal(input int bits, input int size);
        return (size >= 2) && (size <= (1 << bits));
    endfunction

endpackage

// File: rtl/rr_arb_idx_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational wrap-around priority scan. Returns the first set request
// bit found scanning upward from 'start', wrapping from SIZE-1 to 0.
// Ports:
//   req   [SIZE-1:0] in  : request vector
//   start [BITS-1:0] in  : scan start position (always < SIZE)
//   found            out : any request set
//   index [BITS-1:0] out : winning position (0 when nothing found)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int BITS = 2,
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] req,
    input  logic [BITS-1:0] start,
    output logic            found,
    output logic [BITS-1:0] index
);

    logic            w_hi_found;
    logic [BITS-1:0] w_hi_idx;
    logic [BITS-1:0] w_lo_idx;

    // Two priority views: lowest set bit at/above start, and lowest set bit
    // overall. The overall one is only used when nothing is at/above start,
    // which is exactly the wrap-around case. Descending loop makes the
    // lowest position the final assignment.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_idx = BITS'(i);
                if (BITS'(i) >= start) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = BITS'(i);
                end
            end
        end
    end

    assign found = |req;
    assign index = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/rr_arb_idx.sv
// ---------------------------------------------------------------------------
// rr_arb_idx
// Round-robin arbiter producing a registered binary grant index with a
// valid/ready handshake toward a downstream one-hot decoder. One grant per
// cycle under continuous ready; a grant is never retracted while stalled.
// Optional feature macro: RR_ARB_LOCK_EN adds a 'lock' input that re-grants
// the current index on handshake while its request is still asserted.
// Ports:
//   clk        in  : rising-edge clock
//   rst        in  : synchronous active-high reset
//   req        in  : request levels, bit i = requester i
//   idx_ready  in  : downstream accepts idx this cycle
//   lock       in  : (RR_ARB_LOCK_EN only) hold grant on current requester
//   idx_valid  out : grant index offered
//   idx        out : granted requester index
//   ptr        out : round-robin scan start pointer (observation)
// ---------------------------------------------------------------------------
module rr_arb_idx
    import rr_arb_idx_pkg::*;
#(
    parameter int BITS = 2,
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] req,
    input  logic            idx_ready,
`ifdef RR_ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic            idx_valid,
    output logic [BITS-1:0] idx,
    output logic [BITS-1:0] ptr
);

    generate
        if (!size_legal(BITS, SIZE)) begin : g_bad_size
            $error("rr_arb_idx: SIZE must satisfy 2 <= SIZE <= 2**BITS");
        end
    endgenerate

    st_e             r_state;
    logic [BITS-1:0] r_idx;
    logic [BITS-1:0] r_ptr;

    st_e             w_state_nx;
    logic [BITS-1:0] w_idx_nx;
    logic [BITS-1:0] w_ptr_nx;
    logic [BITS-1:0] w_ptr_adv;
    logic [BITS-1:0] w_start;
    logic            w_found;
    logic [BITS-1:0] w_pick;
    logic            w_hs;
    logic            w_hold;

    assign w_hs      = (r_state == ST_GRANT) && idx_ready;
    assign w_ptr_adv = (r_idx == BITS'(SIZE - 1)) ? '0 : r_idx + 1'b1;

    // On a handshake the next grant must already honour the advanced
    // pointer, so the scan starts from it rather than the registered ptr.
    assign w_start = (r_state == ST_GRANT) ? w_ptr_adv : r_ptr;

`ifdef RR_ARB_LOCK_EN
    localparam int NUMW = 1 << BITS;
    logic [NUMW-1:0] w_req_ext;
    assign w_req_ext = NUMW'(req);
    assign w_hold    = lock & w_req_ext[r_idx];
`else
    assign w_hold    = 1'b0;
`endif

    rr_pick #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_pick (
        .req   (req),
        .start (w_start),
        .found (w_found),
        .index (w_pick)
    );

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_ptr_nx   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_idx_nx   = w_pick;
                    w_state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Locked handshake: keep idx and ptr, stay in grant.
                if (w_hs && !w_hold) begin
                    w_ptr_nx = w_ptr_adv;
                    if (w_found) begin
                        w_idx_nx = w_pick;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    assign idx_valid = (r_state == ST_GRANT);
    assign idx       = r_idx;
    assign ptr       = r_ptr;

endmodule

// File: tb/tb_rr_arb_idx.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_idx
// Directed bench for rr_arb_idx. Two instances: a default 4-requester one
// and a 3-requester one (BITS=2) to cover the non-power-of-two wrap. A
// reference model computes grant/pointer from the arbitration rules and is
// compared on every falling edge; literal expectations pin key points.
// ---------------------------------------------------------------------------
module tb_rr_arb_idx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = '0;
    logic       rdy_a = 1'b0;
    logic [2:0] req_b = '0;
    logic       rdy_b = 1'b0;
    logic       lock_a = 1'b0;

    logic       vld_a, vld_b;
    logic [1:0] idx_a, idx_b, ptr_a, ptr_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    rr_arb_idx #(.BITS(2), .SIZE(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req       (req_a),
        .idx_ready (rdy_a),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock_a),
`endif
        .idx_valid (vld_a),
        .idx       (idx_a),
        .ptr       (ptr_a)
    );

    rr_arb_idx #(.BITS(2), .SIZE(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req_b),
        .idx_ready (rdy_b),
`ifdef RR_ARB_LOCK_EN
        .lock      (1'b0),
`endif
        .idx_valid (vld_b),
        .idx       (idx_b),
        .ptr       (ptr_b)
    );

    // ---------------- reference model ----------------
    function automatic int first_from(input int r, input int start, input int size);
        for (int k = 0; k < size; k++) begin
            int j;
            j = (start + k) % size;
            if (((r >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    function automatic void model_step(input int size, input bit r_st, input int r,
                                       input bit rdy, input bit lk,
                                       inout bit v, inout int ix, inout int p);
        int f;
        if (r_st) begin
            v = 0; ix = 0; p = 0;
        end else if (!v) begin
            f = first_from(r, p, size);
            if (f >= 0) begin ix = f; v = 1; end
        end else if (rdy) begin
            if (!(lk && (((r >> ix) & 1) != 0))) begin
                p = (ix + 1) % size;
                f = first_from(r, p, size);
                if (f >= 0) ix = f; else v = 0;
            end
        end
    endfunction

    bit m_va = 0, m_vb = 0;
    int m_ixa = 0, m_pa = 0, m_ixb = 0, m_pb = 0;
    bit lk_eff;

    always @(posedge clk) begin
`ifdef RR_ARB_LOCK_EN
        lk_eff = lock_a;
`else
        lk_eff = 1'b0;
`endif
        model_step(4, rst, int'(req_a), rdy_a, lk_eff, m_va, m_ixa, m_pa);
        model_step(3, rst, int'(req_b), rdy_b, 1'b0, m_vb, m_ixb, m_pb);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_a_valid", int'(vld_a), int'(m_va));
            check("mdl_a_idx",   int'(idx_a), m_ixa);
            check("mdl_a_ptr",   int'(ptr_a), m_pa);
            check("mdl_b_valid", int'(vld_b), int'(m_vb));
            check("mdl_b_idx",   int'(idx_b), m_ixb);
            check("mdl_b_ptr",   int'(ptr_b), m_pb);
            check("b_idx_range", int'(idx_b < 2'd3), 1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int exp_seq [5] = '{0, 1, 2, 3, 0};
    int exp_b   [4] = '{0, 1, 2, 0};

    initial begin
        tick(); tick();
        rst = 1'b0;
        cmp_en = 1'b1;
        check("rst_valid", int'(vld_a), 0);
        check("rst_idx",   int'(idx_a), 0);
        check("rst_ptr",   int'(ptr_a), 0);

        // full request, ready held: one grant per cycle in rotation
        req_a = 4'b1111; rdy_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rot_valid", int'(vld_a), 1);
            check("rot_idx",   int'(idx_a), exp_seq[i]);
        end
        req_a = 4'b0000;
        tick();
        check("rot_end_valid", int'(vld_a), 0);
        check("rot_end_ptr",   int'(ptr_a), 1);

        // single-cycle request, stalled downstream: grant holds
        req_a = 4'b0100; rdy_a = 1'b0;
        tick();
        req_a = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", int'(vld_a), 1);
            check("stall_idx",   int'(idx_a), 2);
            tick();
        end
        rdy_a = 1'b1;
        tick();
        check("stall_hs_ptr",   int'(ptr_a), 3);
        check("stall_hs_valid", int'(vld_a), 0);

        // ready while idle is ignored
        tick(); tick();
        check("idle_rdy_ptr",   int'(ptr_a), 3);
        check("idle_rdy_valid", int'(vld_a), 0);

        // wrap from ptr=3
        req_a = 4'b1001;
        tick();
        check("wrap_idx3", int'(idx_a), 3);
        tick();
        check("wrap_idx0", int'(idx_a), 0);
        check("wrap_ptr0", int'(ptr_a), 0);
        req_a = 4'b0000;
        tick();
        check("wrap_end_ptr", int'(ptr_a), 1);

        // reset mid-grant overrides the handshake
        req_a = 4'b0010; rdy_a = 1'b0;
        tick();
        check("pre_rst_idx", int'(idx_a), 1);
        rst = 1'b1; rdy_a = 1'b1; req_a = 4'b1111;
        tick();
        rst = 1'b0; req_a = 4'b0000;
        check("mid_rst_valid", int'(vld_a), 0);
        check("mid_rst_idx",   int'(idx_a), 0);
        check("mid_rst_ptr",   int'(ptr_a), 0);

        // SIZE=3 rotation must wrap at 2
        req_b = 3'b111; rdy_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b_rot_idx", int'(idx_b), exp_b[i]);
        end
        req_b = 3'b000;
        tick();
        check("b_end_valid", int'(vld_b), 0);

`ifdef RR_ARB_LOCK_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = 4'b0011; rdy_a = 1'b1; lock_a = 1'b1;
        tick();
        check("lock_first", int'(idx_a), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lock_hold_idx", int'(idx_a), 0);
            check("lock_hold_ptr", int'(ptr_a), 0);
        end
        lock_a = 1'b0;
        tick();
        check("lock_release_idx", int'(idx_a), 1);
        req_a = 4'b0000;
        tick();
`endif

        tick();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
